// File: rtl/arty_parrot_nbf_bridge.sv
// rtl/arty_parrot_nbf_bridge.sv - UART NBF command bridge to an on-chip 64-bit scratchpad
module arty_parrot_nbf_bridge #(
  parameter int          clk_per_bit_p = 868,
  parameter int          mem_els_p     = 512,
  parameter logic [39:0] mem_base_p    = 40'h00_8000_0000
) (
  input  logic master_clk_100mhz_i,
  input  logic reset_i,
  input  logic uart_rx_i,
  output logic uart_tx_o,
  output logic reset_led_o,
  output logic error_led_o
);

  localparam int          aw           = $clog2(mem_els_p);
  localparam logic [40:0] mem_end_lp   = {1'b0, mem_base_p} + 41'(8 * mem_els_p);
  localparam logic [15:0] bit_last_lp  = 16'(clk_per_bit_p - 1);
  localparam logic [15:0] half_last_lp = 16'(clk_per_bit_p / 2 - 1);

  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_e;
  typedef enum logic [1:0] {X_IDLE, X_ISSUE, X_CAPTURE, X_TX} x_state_e;

  rx_state_e rx_state;
  logic        rx_s1, rx_s2, rx_prev;
  logic [15:0] rx_cnt;
  logic [2:0]  rx_bit;
  logic [7:0]  rx_shift, rx_byte;
  logic        rx_valid, rx_ferr;

  x_state_e x_state;
  logic [111:0] pkt_buf, pend_pkt, tx_buf;
  logic [3:0]   byte_cnt, tx_bit, tx_byte;
  logic         pend_full;
  logic [7:0]   cmd_op;
  logic [39:0]  cmd_addr;
  logic [63:0]  cmd_data;
  logic [15:0]  tx_cnt;

  logic [63:0]   mem [mem_els_p];
  logic [63:0]   mem_rdata;
  logic [aw-1:0] mem_idx;
  logic [39:0]   addr_offs;
  logic [7:0]    lane_mask, be;
  logic [63:0]   wdata, rd_shift, rd_data;
  logic          is_wr, is_rd, is_ctl, aligned, in_range, acc_ok, bad_cmd, mem_we;
  logic          pkt_done, tx_done_now, take;

  always_ff @(posedge master_clk_100mhz_i or posedge reset_i) begin
    if (reset_i) reset_led_o <= 1'b1;
    else         reset_led_o <= 1'b0;
  end

  // Receiver: 2-flop synchronizer, falling-edge start detect, mid-bit sampling
  always_ff @(posedge master_clk_100mhz_i or posedge reset_i) begin
    if (reset_i) begin
      rx_s1    <= 1'b1;
      rx_s2    <= 1'b1;
      rx_prev  <= 1'b1;
      rx_state <= RX_IDLE;
      rx_cnt   <= '0;
      rx_bit   <= '0;
      rx_shift <= '0;
      rx_byte  <= '0;
      rx_valid <= 1'b0;
      rx_ferr  <= 1'b0;
    end else begin
      rx_s1    <= uart_rx_i;
      rx_s2    <= rx_s1;
      rx_prev  <= rx_s2;
      rx_valid <= 1'b0;
      rx_ferr  <= 1'b0;
      case (rx_state)
        RX_IDLE: if (rx_prev && !rx_s2) begin
          rx_state <= RX_START;
          rx_cnt   <= '0;
        end
        RX_START: if (rx_cnt == half_last_lp) begin
          rx_cnt   <= '0;
          rx_bit   <= '0;
          rx_state <= rx_s2 ? RX_IDLE : RX_DATA;
        end else rx_cnt <= rx_cnt + 16'd1;
        RX_DATA: if (rx_cnt == bit_last_lp) begin
          rx_cnt   <= '0;
          rx_shift <= {rx_s2, rx_shift[7:1]};
          rx_bit   <= rx_bit + 3'd1;
          if (rx_bit == 3'd7) rx_state <= RX_STOP;
        end else rx_cnt <= rx_cnt + 16'd1;
        RX_STOP: if (rx_cnt == bit_last_lp) begin
          rx_cnt   <= '0;
          rx_state <= RX_IDLE;
          if (rx_s2) begin
            rx_valid <= 1'b1;
            rx_byte  <= rx_shift;
          end else rx_ferr <= 1'b1;
        end else rx_cnt <= rx_cnt + 16'd1;
        default: rx_state <= RX_IDLE;
      endcase
    end
  end

  always_comb begin
    is_wr     = cmd_op inside {8'h00, 8'h01, 8'h02, 8'h03};
    is_rd     = cmd_op inside {8'h10, 8'h11, 8'h12, 8'h13};
    is_ctl    = cmd_op inside {8'hFE, 8'hFF};
    aligned   = 1'b1;
    lane_mask = 8'h01;
    case (cmd_op[1:0])
      2'd0: begin aligned = 1'b1;                  lane_mask = 8'h01; end
      2'd1: begin aligned = !cmd_addr[0];          lane_mask = 8'h03; end
      2'd2: begin aligned = cmd_addr[1:0] == 2'd0; lane_mask = 8'h0F; end
      default: begin aligned = cmd_addr[2:0] == 3'd0; lane_mask = 8'hFF; end
    endcase
    in_range  = ({1'b0, cmd_addr} >= {1'b0, mem_base_p}) && ({1'b0, cmd_addr} < mem_end_lp);
    acc_ok    = (is_wr || is_rd) && aligned && in_range;
    bad_cmd   = !is_ctl && !acc_ok;
    addr_offs = cmd_addr - mem_base_p;
    mem_idx   = addr_offs[aw+2:3];
    be        = lane_mask << cmd_addr[2:0];
    wdata     = cmd_data << {cmd_addr[2:0], 3'b000};
    mem_we    = (x_state == X_ISSUE) && is_wr && acc_ok;
    rd_shift  = mem_rdata >> {cmd_addr[2:0], 3'b000};
    case (cmd_op[1:0])
      2'd0:    rd_data = {56'd0, rd_shift[7:0]};
      2'd1:    rd_data = {48'd0, rd_shift[15:0]};
      2'd2:    rd_data = {32'd0, rd_shift[31:0]};
      default: rd_data = rd_shift;
    endcase
  end

  always_ff @(posedge master_clk_100mhz_i) begin
    if (mem_we)
      for (int b = 0; b < 8; b++)
        if (be[b]) mem[mem_idx][8*b +: 8] <= wdata[8*b +: 8];
    mem_rdata <= mem[mem_idx];
  end

  assign pkt_done    = rx_valid && (byte_cnt == 4'd13);
  assign tx_done_now = (x_state == X_TX) && (tx_cnt == bit_last_lp) &&
                       (tx_bit == 4'd9) && (tx_byte == 4'd13);
  // Pending is drained in the same cycle the last stop bit finishes, so a
  // packet completing then is not an overflow.
  assign take        = pend_full && ((x_state == X_IDLE) || tx_done_now);

  always_ff @(posedge master_clk_100mhz_i or posedge reset_i) begin
    if (reset_i) begin
      pkt_buf     <= '0;
      pend_pkt    <= '0;
      pend_full   <= 1'b0;
      byte_cnt    <= '0;
      x_state     <= X_IDLE;
      cmd_op      <= '0;
      cmd_addr    <= '0;
      cmd_data    <= '0;
      tx_buf      <= '0;
      tx_cnt      <= '0;
      tx_bit      <= '0;
      tx_byte     <= '0;
      uart_tx_o   <= 1'b1;
      error_led_o <= 1'b0;
    end else begin
      if (rx_ferr) error_led_o <= 1'b1;
      if (rx_valid) begin
        byte_cnt <= (byte_cnt == 4'd13) ? 4'd0 : byte_cnt + 4'd1;
        pkt_buf  <= {rx_byte, pkt_buf[111:8]};
      end
      if (pkt_done && pend_full && !take) error_led_o <= 1'b1;
      else if (pkt_done) begin
        pend_pkt  <= {rx_byte, pkt_buf[111:8]};
        pend_full <= 1'b1;
      end else if (take) pend_full <= 1'b0;

      if (take) begin
        cmd_op   <= pend_pkt[111:104];
        cmd_addr <= pend_pkt[103:64];
        cmd_data <= pend_pkt[63:0];
      end

      case (x_state)
        X_IDLE: if (take) x_state <= X_ISSUE;
        X_ISSUE: x_state <= X_CAPTURE;
        X_CAPTURE: begin
          if (bad_cmd) error_led_o <= 1'b1;
          tx_buf    <= {cmd_op, cmd_addr, (is_rd && acc_ok) ? rd_data : 64'd0};
          tx_cnt    <= '0;
          tx_bit    <= '0;
          tx_byte   <= '0;
          uart_tx_o <= 1'b0;
          x_state   <= X_TX;
        end
        X_TX: if (tx_cnt == bit_last_lp) begin
          tx_cnt <= '0;
          if (tx_bit == 4'd9) begin
            if (tx_byte == 4'd13) begin
              uart_tx_o <= 1'b1;
              x_state   <= take ? X_ISSUE : X_IDLE;
            end else begin
              tx_byte   <= tx_byte + 4'd1;
              tx_buf    <= {8'h00, tx_buf[111:8]};
              tx_bit    <= '0;
              uart_tx_o <= 1'b0;
            end
          end else begin
            tx_bit    <= tx_bit + 4'd1;
            uart_tx_o <= (tx_bit == 4'd8) ? 1'b1 : tx_buf[tx_bit[2:0]];
          end
        end else tx_cnt <= tx_cnt + 16'd1;
        default: x_state <= X_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_arty_parrot_nbf_bridge.sv
// tb/tb_arty_parrot_nbf_bridge.sv - scoreboard bench for the UART NBF bridge
module tb_arty_parrot_nbf_bridge;
  localparam int cpb = 20;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic rx  = 1'b1;
  logic tx, rled, eled;

  int checks = 0;
  int errors = 0;
  int resp_cnt = 0;
  logic [111:0] exp_q[$];

  always #5 clk = ~clk;

  arty_parrot_nbf_bridge #(.clk_per_bit_p(cpb)) dut (
    .master_clk_100mhz_i(clk),
    .reset_i(rst),
    .uart_rx_i(rx),
    .uart_tx_o(tx),
    .reset_led_o(rled),
    .error_led_o(eled)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop);
    rx = 1'b0;
    repeat (cpb) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      repeat (cpb) @(negedge clk);
    end
    rx = stop;
    repeat (cpb) @(negedge clk);
    rx = 1'b1;
    if (!stop) repeat (2 * cpb) @(negedge clk);
  endtask

  task automatic send_cmd(input logic [7:0] op, input logic [39:0] addr,
                          input logic [63:0] data, input logic [63:0] exp_data);
    logic [111:0] p;
    p = {op, addr, data};
    exp_q.push_back({op, addr, exp_data});
    for (int i = 0; i < 14; i++) send_byte(p[8*i +: 8], 1'b1);
  endtask

  task automatic wait_resp(input int target, input string tag);
    int t;
    t = 0;
    while (resp_cnt < target && t < 8000) begin
      @(negedge clk);
      t++;
    end
    check(tag, 64'(resp_cnt), 64'(target));
  endtask

  // Response monitor: decodes 14 UART bytes and compares against the scoreboard
  initial begin
    logic [111:0] got, e;
    logic [7:0] b;
    got = '0;
    b = '0;
    @(negedge rst);
    forever begin
      for (int k = 0; k < 14; k++) begin
        while (tx !== 1'b0) @(negedge clk);
        repeat (cpb / 2) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
          repeat (cpb) @(negedge clk);
          b[i] = tx;
        end
        repeat (cpb) @(negedge clk);
        check("stop_bit", 64'(tx), 64'd1);
        got[8*k +: 8] = b;
      end
      check("sb_nonempty", 64'(exp_q.size() > 0), 64'd1);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("resp_op", 64'(got[111:104]), 64'(e[111:104]));
        check("resp_addr", 64'(got[103:64]), 64'(e[103:64]));
        check("resp_data", got[63:0], e[63:0]);
      end
      resp_cnt++;
    end
  end

  initial begin
    rst = 1'b1;
    rx = 1'b1;
    repeat (4) @(negedge clk);
    check("rst_tx", 64'(tx), 64'd1);
    check("rst_led_on", 64'(rled), 64'd1);
    check("rst_err", 64'(eled), 64'd0);
    repeat (60) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("rst_led_off", 64'(rled), 64'd0);
    repeat (10) @(negedge clk);

    send_cmd(8'h03, 40'h00_8000_0000, 64'hAB, 64'd0);
    wait_resp(1, "resp_w8");
    send_cmd(8'h13, 40'h00_8000_0000, 64'd0, 64'hAB);
    wait_resp(2, "resp_r8");
    check("err_clean", 64'(eled), 64'd0);

    send_cmd(8'h03, 40'h00_8000_0010, 64'd0, 64'd0);
    wait_resp(3, "resp_clr");
    send_cmd(8'h02, 40'h00_8000_0010, 64'h1122_3344_5566_7788, 64'd0);
    wait_resp(4, "resp_w4");
    send_cmd(8'h13, 40'h00_8000_0010, 64'd0, 64'h0000_0000_5566_7788);
    wait_resp(5, "resp_r8b");
    send_cmd(8'h11, 40'h00_8000_0012, 64'd0, 64'h5566);
    wait_resp(6, "resp_r2");
    check("err_still_clean", 64'(eled), 64'd0);

    send_cmd(8'h13, 40'h00_9000_0000, 64'd0, 64'd0);
    wait_resp(7, "resp_oor");
    check("err_oor", 64'(eled), 64'd1);
    repeat (200) @(negedge clk);
    check("err_sticky", 64'(eled), 64'd1);

    rst = 1'b1;
    repeat (4) @(negedge clk);
    check("err_reset", 64'(eled), 64'd0);
    rst = 1'b0;
    repeat (10) @(negedge clk);

    send_byte(8'h3C, 1'b0);
    repeat (5) @(negedge clk);
    check("err_frame", 64'(eled), 64'd1);
    send_cmd(8'h00, 40'h00_8000_0008, 64'h5A, 64'd0);
    wait_resp(8, "resp_w1");
    send_cmd(8'h10, 40'h00_8000_0008, 64'd0, 64'h5A);
    wait_resp(9, "resp_r1");
    check("err_frame_sticky", 64'(eled), 64'd1);
    check("sb_empty", 64'(exp_q.size()), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
